// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: parser/solver/assembler handshakes, shared line FIFO port and board descriptor.
interface phase_sequencer_if #(
  parameter int MAX_ROWS        = 11,
  parameter int MAX_COLS        = 11,
  parameter int MAX_NUM_OPTIONS = 84,
  parameter int LINE_W          = 16
);
  localparam int NL = MAX_ROWS + MAX_COLS;
  localparam int RW = $clog2(MAX_ROWS + 1);
  localparam int CW = $clog2(MAX_COLS + 1);
  localparam int OW = $clog2(MAX_NUM_OPTIONS + 1);
  logic              rx_valid;
  logic              parser_valid;
  logic              parse_done;
  logic              parse_write;
  logic [LINE_W-1:0] parse_line;
  logic [RW-1:0]     parse_m;
  logic [CW-1:0]     parse_n;
  logic [NL*OW-1:0]  parse_opts;
  logic              solve_write;
  logic [LINE_W-1:0] solve_line;
  logic              solve_next;
  logic              solved;
  logic              assembled;
  logic [LINE_W-1:0] fifo_din;
  logic              fifo_wr_en;
  logic              fifo_rd_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic [RW-1:0]     m_out;
  logic [CW-1:0]     n_out;
  logic [NL*OW-1:0]  opts_out;
  logic              solve_start;
  logic              asm_start;
  logic [1:0]        state;
  logic [1:0]        err;
  logic [7:0]        board_count;
  modport slave (
    input  rx_valid, parse_done, parse_write, parse_line, parse_m, parse_n, parse_opts,
           solve_write, solve_line, solve_next, solved, assembled, fifo_full, fifo_empty,
    output parser_valid, fifo_din, fifo_wr_en, fifo_rd_en, m_out, n_out, opts_out,
           solve_start, asm_start, state, err, board_count
  );
  modport master (
    output rx_valid, parse_done, parse_write, parse_line, parse_m, parse_n, parse_opts,
           solve_write, solve_line, solve_next, solved, assembled, fifo_full, fifo_empty,
    input  parser_valid, fifo_din, fifo_wr_en, fifo_rd_en, m_out, n_out, opts_out,
           solve_start, asm_start, state, err, board_count
  );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer: receive/solve/transmit/flush phase FSM owning the shared line FIFO, with solve watchdog and overflow recovery.
module phase_sequencer #(
  parameter int MAX_ROWS        = 11,
  parameter int MAX_COLS        = 11,
  parameter int MAX_NUM_OPTIONS = 84,
  parameter int LINE_W          = 16,
  parameter int SOLVE_TIMEOUT   = 50_000_000
) (
  input logic               clk,
  input logic               rst,
  phase_sequencer_if.slave  bus
);
  localparam int NL = MAX_ROWS + MAX_COLS;
  localparam int RW = $clog2(MAX_ROWS + 1);
  localparam int CW = $clog2(MAX_COLS + 1);
  localparam int OW = $clog2(MAX_NUM_OPTIONS + 1);
  localparam int WW = $clog2(SOLVE_TIMEOUT + 1);
  typedef enum logic [1:0] {RECEIVE = 2'd0, SOLVE = 2'd1, TRANSMIT = 2'd2, FLUSH = 2'd3} state_e;
  state_e           state_q, state_d;
  logic [1:0]       err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [RW-1:0]    m_q, m_d;
  logic [CW-1:0]    n_q, n_d;
  logic [NL*OW-1:0] opts_q, opts_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic             solve_start_q, solve_start_d;
  logic             asm_start_q, asm_start_d;
  logic             wr_req, ovf, expire;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RECEIVE;
      err_q         <= '0;
      cnt_q         <= '0;
      m_q           <= '0;
      n_q           <= '0;
      opts_q        <= '0;
      wd_q          <= '0;
      solve_start_q <= 1'b0;
      asm_start_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
      m_q           <= m_d;
      n_q           <= n_d;
      opts_q        <= opts_d;
      wd_q          <= wd_d;
      solve_start_q <= solve_start_d;
      asm_start_q   <= asm_start_d;
    end
  end
  // Overflow outranks every phase event; solved outranks a coincident watchdog expiry.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    n_d     = n_q;
    opts_d  = opts_q;
    wd_d    = state_q == SOLVE ? wd_q + WW'(1) : '0;
    if (ovf) begin
      state_d = FLUSH;
      err_d   = err_q | 2'b10;
    end else if (state_q == RECEIVE && bus.parse_done) begin
      state_d = SOLVE;
      err_d   = '0;
      m_d     = bus.parse_m;
      n_d     = bus.parse_n;
      opts_d  = bus.parse_opts;
    end else if (state_q == SOLVE && bus.solved) begin
      state_d = TRANSMIT;
    end else if (state_q == SOLVE && expire) begin
      state_d = FLUSH;
      err_d   = err_q | 2'b01;
    end else if (state_q == TRANSMIT && bus.assembled) begin
      state_d = RECEIVE;
      cnt_d   = cnt_q + 8'd1;
    end else if (state_q == FLUSH && bus.fifo_empty) begin
      state_d = RECEIVE;
    end
    solve_start_d = state_d == SOLVE && state_q != SOLVE;
    asm_start_d   = state_d == TRANSMIT && state_q != TRANSMIT;
  end
  always_comb begin
    wr_req           = state_q == RECEIVE ? bus.parse_write : state_q == SOLVE ? bus.solve_write : 1'b0;
    ovf              = wr_req && bus.fifo_full;
    expire           = wd_q == WW'(SOLVE_TIMEOUT - 1);
    bus.parser_valid = bus.rx_valid && state_q == RECEIVE;
    bus.fifo_din     = state_q == SOLVE ? bus.solve_line : bus.parse_line;
    bus.fifo_wr_en   = wr_req && !bus.fifo_full;
    bus.fifo_rd_en   = state_q == SOLVE ? bus.solve_next : state_q == FLUSH ? !bus.fifo_empty : 1'b0;
  end
  assign bus.state       = state_q;
  assign bus.err         = err_q;
  assign bus.board_count = cnt_q;
  assign bus.m_out       = m_q;
  assign bus.n_out       = n_q;
  assign bus.opts_out    = opts_q;
  assign bus.solve_start = solve_start_q;
  assign bus.asm_start   = asm_start_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed phase scenarios plus randomized traffic against a phase-level reference model.
module tb_phase_sequencer;
  localparam int T  = 16;
  localparam int NL = 22;
  localparam int OW = $clog2(85);
  localparam int RW = $clog2(12);
  localparam int CW = $clog2(12);
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int failures = 0;
  phase_sequencer_if bus ();
  phase_sequencer #(.SOLVE_TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int               e_st;
  logic [1:0]       e_err;
  logic [7:0]       e_cnt;
  logic [RW-1:0]    e_m;
  logic [CW-1:0]    e_n;
  logic [NL*OW-1:0] e_opts;
  int               e_sc;
  bit               e_ss, e_as;
  task automatic idle();
    bus.rx_valid = 0; bus.parse_done = 0; bus.parse_write = 0; bus.parse_line = '0;
    bus.parse_m = '0; bus.parse_n = '0; bus.parse_opts = '0;
    bus.solve_write = 0; bus.solve_line = '0; bus.solve_next = 0;
    bus.solved = 0; bus.assembled = 0; bus.fifo_full = 0; bus.fifo_empty = 1;
  endtask
  task automatic rand_opts();
    for (int i = 0; i < NL*OW; i++) bus.parse_opts[i] = 1'($urandom_range(1, 0));
  endtask
  // Advances one clock and applies the phase rules to the inputs present at that edge.
  task automatic tick();
    bit wr, ov;
    @(posedge clk);
    wr = (e_st == 0 && bus.parse_write) || (e_st == 1 && bus.solve_write);
    ov = wr && bus.fifo_full;
    e_ss = 0; e_as = 0;
    if (rst) begin
      e_st = 0; e_err = 0; e_cnt = 0; e_m = 0; e_n = 0; e_opts = 0; e_sc = 0;
    end else if (ov) begin
      e_st = 3; e_err[1] = 1'b1;
    end else case (e_st)
      0: if (bus.parse_done) begin
        e_st = 1; e_err = 0; e_m = bus.parse_m; e_n = bus.parse_n; e_opts = bus.parse_opts; e_sc = 0; e_ss = 1;
      end
      1: begin
        e_sc++;
        if (bus.solved) begin e_st = 2; e_as = 1; end
        else if (e_sc == T) begin e_st = 3; e_err[0] = 1'b1; end
      end
      2: if (bus.assembled) begin e_st = 0; e_cnt++; end
      3: if (bus.fifo_empty) e_st = 0;
      default: ;
    endcase
    #1;
  endtask
  task automatic test_reset();
    idle(); rst = 1; tick(); rst = 0;
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.err !== 2'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", bus.err); end
    checks++; if (bus.board_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.board_count); end
    checks++; if (bus.m_out !== '0 || bus.n_out !== '0 || bus.opts_out !== '0) begin failures++; $display("FAIL reset_desc m=%0d n=%0d", bus.m_out, bus.n_out); end
    checks++; if (bus.solve_start !== 1'b0 || bus.asm_start !== 1'b0) begin failures++; $display("FAIL reset_pulses ss=%0b as=%0b exp=0", bus.solve_start, bus.asm_start); end
  endtask
  task automatic test_full_pass();
    logic [NL*OW-1:0] o;
    idle();
    bus.parse_write = 1; bus.parse_line = 16'hA5C3; bus.rx_valid = 1; #1;
    checks++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 16'hA5C3) begin failures++; $display("FAIL rx_fifo_wr wr=%0b din=%h exp=1/a5c3", bus.fifo_wr_en, bus.fifo_din); end
    checks++; if (bus.parser_valid !== 1'b1) begin failures++; $display("FAIL rx_parser_valid got=%0b exp=1", bus.parser_valid); end
    tick(); idle();
    bus.parse_m = 11; bus.parse_n = 11; rand_opts(); o = bus.parse_opts; bus.parse_done = 1;
    tick(); idle();
    checks++; if (bus.state !== 2'd1 || bus.solve_start !== 1'b1) begin failures++; $display("FAIL pass_enter st=%0d ss=%0b exp=1/1", bus.state, bus.solve_start); end
    checks++; if (bus.m_out !== 4'd11 || bus.n_out !== 4'd11 || bus.opts_out !== o) begin failures++; $display("FAIL pass_latch m=%0d n=%0d exp=11/11", bus.m_out, bus.n_out); end
    bus.solve_write = 1; bus.solve_line = 16'h1234; bus.solve_next = 1; bus.parse_write = 1; bus.parse_line = 16'hFFFF; #1;
    checks++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 16'h1234 || bus.fifo_rd_en !== 1'b1) begin failures++; $display("FAIL solve_fifo wr=%0b din=%h rd=%0b exp=1/1234/1", bus.fifo_wr_en, bus.fifo_din, bus.fifo_rd_en); end
    tick(); idle();
    checks++; if (bus.solve_start !== 1'b0) begin failures++; $display("FAIL pass_ss_once got=%0b exp=0", bus.solve_start); end
    bus.solved = 1; tick(); idle();
    checks++; if (bus.state !== 2'd2 || bus.asm_start !== 1'b1) begin failures++; $display("FAIL pass_tx st=%0d as=%0b exp=2/1", bus.state, bus.asm_start); end
    bus.parse_write = 1; bus.solve_next = 1; #1;
    checks++; if (bus.fifo_wr_en !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL tx_fifo wr=%0b rd=%0b exp=0/0", bus.fifo_wr_en, bus.fifo_rd_en); end
    tick(); idle();
    checks++; if (bus.asm_start !== 1'b0 || bus.state !== 2'd2) begin failures++; $display("FAIL pass_as_once as=%0b st=%0d exp=0/2", bus.asm_start, bus.state); end
    bus.assembled = 1; tick(); idle();
    checks++; if (bus.state !== 2'd0 || bus.board_count !== 8'd1) begin failures++; $display("FAIL pass_done st=%0d cnt=%0d exp=0/1", bus.state, bus.board_count); end
  endtask
  task automatic test_timeout();
    logic [7:0] c;
    idle(); c = bus.board_count;
    bus.parse_done = 1; tick(); idle();
    repeat (T - 1) tick();
    checks++; if (bus.state !== 2'd1 || bus.err !== 2'd0) begin failures++; $display("FAIL to_early st=%0d err=%0d exp=1/0", bus.state, bus.err); end
    tick();
    checks++; if (bus.state !== 2'd3 || bus.err !== 2'b01) begin failures++; $display("FAIL to_fire st=%0d err=%0d exp=3/1", bus.state, bus.err); end
    bus.fifo_empty = 0; #1;
    checks++; if (bus.fifo_rd_en !== 1'b1) begin failures++; $display("FAIL flush_rd got=%0b exp=1", bus.fifo_rd_en); end
    tick();
    checks++; if (bus.state !== 2'd3) begin failures++; $display("FAIL flush_hold st=%0d exp=3", bus.state); end
    bus.fifo_empty = 1; #1;
    checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL flush_rd_empty got=%0b exp=0", bus.fifo_rd_en); end
    tick();
    checks++; if (bus.state !== 2'd0 || bus.err !== 2'b01 || bus.board_count !== c) begin failures++; $display("FAIL flush_exit st=%0d err=%0d cnt=%0d exp=0/1/%0d", bus.state, bus.err, bus.board_count, c); end
    bus.parse_done = 1; tick(); idle();
    checks++; if (bus.err !== 2'b00 || bus.state !== 2'd1) begin failures++; $display("FAIL err_clear err=%0d st=%0d exp=0/1", bus.err, bus.state); end
    bus.solved = 1; tick(); idle(); bus.assembled = 1; tick(); idle();
  endtask
  task automatic test_overflow();
    idle(); bus.parse_write = 1; bus.fifo_full = 1; #1;
    checks++; if (bus.fifo_wr_en !== 1'b0) begin failures++; $display("FAIL ovf_suppress got=%0b exp=0", bus.fifo_wr_en); end
    tick(); idle();
    checks++; if (bus.state !== 2'd3 || bus.err !== 2'b10) begin failures++; $display("FAIL ovf_flush st=%0d err=%0d exp=3/2", bus.state, bus.err); end
    tick();
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL ovf_exit st=%0d exp=0", bus.state); end
  endtask
  task automatic test_coincide();
    idle(); bus.parse_done = 1; tick(); idle();
    repeat (T - 1) tick();
    bus.solved = 1; tick(); idle();
    checks++; if (bus.state !== 2'd2 || bus.err !== 2'b00) begin failures++; $display("FAIL coincide st=%0d err=%0d exp=2/0", bus.state, bus.err); end
    bus.assembled = 1; tick(); idle();
  endtask
  task automatic test_wrap();
    idle(); rst = 1; tick(); rst = 0;
    for (int b = 0; b < 256; b++) begin
      bus.parse_done = 1; tick(); idle();
      if (b == 0) begin
        bus.rx_valid = 1; bus.parse_done = 1; #1;
        checks++; if (bus.parser_valid !== 1'b0) begin failures++; $display("FAIL pv_solve got=%0b exp=0", bus.parser_valid); end
        tick(); idle();
        checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL pd_ignored st=%0d exp=1", bus.state); end
      end
      bus.solved = 1; tick(); idle();
      bus.assembled = 1; tick(); idle();
      if (b == 254) begin
        checks++; if (bus.board_count !== 8'd255) begin failures++; $display("FAIL count_255 got=%0d exp=255", bus.board_count); end
      end
    end
    checks++; if (bus.board_count !== 8'd0) begin failures++; $display("FAIL count_wrap got=%0d exp=0", bus.board_count); end
  endtask
  task automatic test_rst_mid_solve();
    idle(); bus.parse_m = 7; bus.parse_n = 9; rand_opts(); bus.parse_done = 1; tick(); idle();
    repeat (5) tick();
    rst = 1; tick(); rst = 0;
    checks++; if (bus.state !== 2'd0 || bus.err !== 2'd0 || bus.board_count !== 8'd0) begin failures++; $display("FAIL rst_mid st=%0d err=%0d cnt=%0d exp=0", bus.state, bus.err, bus.board_count); end
    checks++; if (bus.m_out !== '0 || bus.n_out !== '0 || bus.opts_out !== '0 || bus.solve_start !== 1'b0 || bus.asm_start !== 1'b0) begin failures++; $display("FAIL rst_mid_desc m=%0d n=%0d exp=0", bus.m_out, bus.n_out); end
  endtask
  task automatic test_random();
    bit wr;
    idle(); rst = 1; tick(); rst = 0;
    for (int k = 0; k < 4000; k++) begin
      bus.rx_valid    = 1'($urandom_range(1, 0));
      bus.parse_done  = $urandom_range(7, 0) == 0;
      bus.parse_write = 1'($urandom_range(1, 0));
      bus.parse_line  = 16'($urandom);
      bus.parse_m     = 4'($urandom_range(11, 0));
      bus.parse_n     = 4'($urandom_range(11, 0));
      rand_opts();
      bus.solve_write = 1'($urandom_range(1, 0));
      bus.solve_line  = 16'($urandom);
      bus.solve_next  = 1'($urandom_range(1, 0));
      bus.solved      = $urandom_range(24, 0) == 0;
      bus.assembled   = $urandom_range(3, 0) == 0;
      bus.fifo_full   = $urandom_range(19, 0) == 0;
      bus.fifo_empty  = 1'($urandom_range(1, 0));
      rst             = $urandom_range(299, 0) == 0;
      #1;
      wr = (e_st == 0 && bus.parse_write) || (e_st == 1 && bus.solve_write);
      checks++; if (bus.parser_valid !== (bus.rx_valid && e_st == 0)) begin failures++; $display("FAIL rnd_pv cyc=%0d got=%0b", k, bus.parser_valid); end
      checks++; if (bus.fifo_wr_en !== (wr && !bus.fifo_full)) begin failures++; $display("FAIL rnd_wr cyc=%0d got=%0b st=%0d", k, bus.fifo_wr_en, e_st); end
      checks++; if (bus.fifo_rd_en !== (e_st == 1 ? bus.solve_next : e_st == 3 ? !bus.fifo_empty : 1'b0)) begin failures++; $display("FAIL rnd_rd cyc=%0d got=%0b st=%0d", k, bus.fifo_rd_en, e_st); end
      if (e_st < 2) begin
        checks++; if (bus.fifo_din !== (e_st == 0 ? bus.parse_line : bus.solve_line)) begin failures++; $display("FAIL rnd_din cyc=%0d got=%h", k, bus.fifo_din); end
      end
      tick();
      checks++; if (bus.state !== 2'(e_st) || bus.err !== e_err || bus.board_count !== e_cnt) begin failures++; $display("FAIL rnd_regs cyc=%0d st=%0d/%0d err=%0d/%0d cnt=%0d/%0d", k, bus.state, e_st, bus.err, e_err, bus.board_count, e_cnt); end
      checks++; if (bus.m_out !== e_m || bus.n_out !== e_n || bus.opts_out !== e_opts) begin failures++; $display("FAIL rnd_desc cyc=%0d m=%0d/%0d n=%0d/%0d", k, bus.m_out, e_m, bus.n_out, e_n); end
      checks++; if (bus.solve_start !== e_ss || bus.asm_start !== e_as) begin failures++; $display("FAIL rnd_pulse cyc=%0d ss=%0b/%0b as=%0b/%0b", k, bus.solve_start, e_ss, bus.asm_start, e_as); end
    end
    rst = 0; idle();
  endtask
  initial begin
    e_st = 0; e_err = 0; e_cnt = 0; e_m = 0; e_n = 0; e_opts = 0; e_sc = 0; e_ss = 0; e_as = 0;
    idle();
    #2;
    test_reset();
    test_full_pass();
    test_timeout();
    test_overflow();
    test_coincide();
    test_wrap();
    test_rst_mid_solve();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameters SHALL be: MAX_ROWS 11, max board rows; MAX_COLS 11, max board columns; MAX_NUM_OPTIONS 84, max options per line; LINE_W 16, FIFO word width; SOLVE_TIMEOUT 50_000_000, solve watchdog in cycles. Derived: NL=MAX_ROWS+MAX_COLS, RW=$clog2(MAX_ROWS+1), CW=$clog2(MAX_COLS+1), OW=$clog2(MAX_NUM_OPTIONS+1).
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single system clock.
- rst  in  1  synchronous active-high reset.
- rx_valid  in  1  UART byte valid.
- parser_valid  out  1  rx_valid gated to RECEIVE.
- parse_done  in  1  board parsed pulse.
- parse_write, parse_line  in  1, LINE_W  parser FIFO write and data.
- parse_m, parse_n, parse_opts  in  RW, CW, NL*OW  parsed dims, options per line.
- solve_write, solve_line  in  1, LINE_W  solver put-back and data.
- solve_next  in  1  solver FIFO read request.
- solved, assembled  in  1, 1  solver done, assembler done.
- fifo_din, fifo_wr_en, fifo_rd_en  out  LINE_W, 1, 1  shared line FIFO.
- fifo_full, fifo_empty  in  1, 1  FIFO flags.
- m_out, n_out, opts_out  out  RW, CW, NL*OW  latched board descriptor.
- solve_start, asm_start  out  1, 1  single-cycle start pulses.
- state  out  2  current phase.
- err  out  2  bit0 timeout, bit1 overflow.
- board_count  out  8  boards completed.

Function
REQ-003 States SHALL be RECEIVE=0, SOLVE=1, TRANSMIT=2, FLUSH=3.
REQ-004 RECEIVE->SOLVE SHALL occur on the edge where parse_done=1; m_out/n_out/opts_out latch parse_m/parse_n/parse_opts on that same edge.
REQ-005 solve_start SHALL be 1 for exactly the first cycle in SOLVE.
REQ-006 SOLVE->TRANSMIT SHALL occur on solved=1; asm_start SHALL be 1 for exactly the first cycle in TRANSMIT.
REQ-007 TRANSMIT->RECEIVE SHALL occur on assembled=1; board_count increments by 1 on that edge, wrapping 255->0.
REQ-008 A watchdog counter SHALL clear on SOLVE entry, increment each SOLVE cycle; on reaching SOLVE_TIMEOUT-1 without solved, set err[0] and go to FLUSH.
REQ-009 If solved and watchdog expiry coincide, solved SHALL win (go to TRANSMIT, err unchanged).
REQ-010 parser_valid SHALL equal rx_valid && state==RECEIVE, combinationally.
REQ-011 fifo_din/fifo_wr_en SHALL combinationally select parse_line/parse_write in RECEIVE, solve_line/solve_write in SOLVE, and drive fifo_wr_en=0 in TRANSMIT and FLUSH.
REQ-012 fifo_rd_en SHALL equal solve_next in SOLVE, !fifo_empty in FLUSH, 0 otherwise.
REQ-013 A selected write request while fifo_full=1 SHALL be suppressed (fifo_wr_en=0), set err[1], and move to FLUSH on the next edge.
REQ-014 FLUSH SHALL drain the FIFO and go to RECEIVE on the first cycle fifo_empty=1; board_count unchanged.
REQ-015 err bits SHALL be sticky and clear only on rst or on RECEIVE->SOLVE.
REQ-016 parse_done outside RECEIVE, solved outside SOLVE, and assembled outside TRANSMIT SHALL be ignored.
REQ-017 state, err, board_count, m_out, n_out, opts_out SHALL be registered outputs.

Reset
REQ-018 On rst=1 at a clock edge, from any state: state=RECEIVE, err=0, board_count=0, m_out/n_out/opts_out=0, watchdog=0, solve_start=asm_start=0.
REQ-019 rst asserted mid-SOLVE or mid-FLUSH SHALL abandon the phase; the FIFO is reset externally by the same rst.

Verification
REQ-020 Full pass: parse_done with m=11,n=11 -> SOLVE, one-cycle solve_start, m_out=11; solved -> one-cycle asm_start; assembled -> RECEIVE, board_count=1.
REQ-021 Timeout with SOLVE_TIMEOUT=16: no solved for 16 cycles -> err=01, FLUSH, rd_en until fifo_empty, then RECEIVE; next parse_done clears err.
REQ-022 Overflow: parse_write=1 with fifo_full=1 in RECEIVE -> fifo_wr_en=0, err=10, FLUSH next cycle.
REQ-023 solved and watchdog expiry in the same cycle -> TRANSMIT, err=00.
REQ-024 256 completed boards -> board_count wraps to 0; rx_valid in SOLVE -> parser_valid=0.
REQ-025 rst pulsed in SOLVE after 5 cycles -> next cycle state=RECEIVE, all registered outputs 0.
